trap_ctrl: RTL and testbench



---
 rtl/trap_pkg.sv | 23 ++
 rtl/trap_prio_enc.sv | 22 ++
 rtl/trap_ctrl.sv | 163 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared definitions for the trap controller.
//   trap_state_e : controller FSM states
//   CSR_*        : register-port addresses
//   SRC_*        : fixed source indices (illegal instruction, overflow)
package trap_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TAKE    = 2'd1,
      HANDLER = 2'd2,
      RETURN  = 2'd3
   } trap_state_e;

   localparam logic [2:0] CSR_MASK     = 3'd0;
   localparam logic [2:0] CSR_PEND     = 3'd1;
   localparam logic [2:0] CSR_EPC      = 3'd2;
   localparam logic [2:0] CSR_CAUSE    = 3'd3;
   localparam logic [2:0] CSR_VEC_BASE = 3'd4;

   localparam int SRC_ILLEGAL = 0;
   localparam int SRC_OVF     = 1;

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
//   i_req  : request vector (already masked)
//   o_hit  : any request set
//   o_sel  : index of the lowest set request (0 when none)
module trap_prio_enc #(
   parameter int NUM_SRC = 8,
   parameter int SEL_W   = $clog2(NUM_SRC + 1)
) (
   input  logic [NUM_SRC-1:0] i_req,
   output logic               o_hit,
   output logic [SEL_W-1:0]   o_sel
);

   always_comb begin
      o_hit = |i_req;
      o_sel = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (i_req[i]) o_sel = SEL_W'(i);
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/exception controller for the multi-cycle core.
// Latches NUM_SRC event sources, picks the lowest unmasked pending one at an
// instruction boundary, redirects the PC to the handler vector, and redirects
// back to EPC on mret.
// Build option: TRAP_VECTORED_EN gives one 4-byte vector slot per source;
// without it every trap goes to VEC_BASE.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   src_pulse             : one-cycle event per source
//   boundary, cur_pc      : FSM at fetch, PC about to be fetched
//   mret                  : return request
//   redirect, redirect_pc : registered PC-load pulse and target
//   in_handler            : high while in the handler
//   csr_we/addr/wdata     : register write port
//   csr_rdata             : combinational register read
//
// state   | meaning
// IDLE    | normal execution, trap may be taken at a boundary
// TAKE    | redirect to vector is being presented
// HANDLER | handler running, new events latch but are not taken
// RETURN  | redirect to EPC is being presented
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter int              NUM_SRC   = 8,
   parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0300
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src_pulse,
   input  logic               boundary,
   input  logic [XLEN-1:0]    cur_pc,
   input  logic               mret,
   output logic               redirect,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               in_handler,
   input  logic               csr_we,
   input  logic [2:0]         csr_addr,
   input  logic [XLEN-1:0]    csr_wdata,
   output logic [XLEN-1:0]    csr_rdata
);

   localparam int CAUSE_W = $clog2(NUM_SRC + 1);

   trap_state_e          r_state;
   trap_state_e          w_state_nxt;
   logic [NUM_SRC-1:0]   r_pend;
   logic [NUM_SRC-1:0]   r_mask;
   logic [XLEN-1:0]      r_epc;
   logic [XLEN-1:0]      r_vec_base;
   logic [CAUSE_W-1:0]   r_cause;
   logic                 r_redirect;
   logic [XLEN-1:0]      r_redirect_pc;

   logic                 w_hit;
   logic [CAUSE_W-1:0]   w_sel;
   logic                 w_take;
   logic                 w_ret;
   logic                 w_wr_mask;
   logic                 w_wr_pend;
   logic                 w_wr_epc;
   logic                 w_wr_vec;
   logic [XLEN-1:0]      w_epc_nxt;
   logic [XLEN-1:0]      w_vec_nxt;
   logic [XLEN-1:0]      w_vector;
   logic [NUM_SRC-1:0]   w_clr;
   logic [NUM_SRC-1:0]   w_pend_nxt;

   trap_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .SEL_W   (CAUSE_W)
   ) u_prio (
      .i_req (r_pend & r_mask),
      .o_hit (w_hit),
      .o_sel (w_sel)
   );

   assign w_wr_mask = csr_we && (csr_addr == CSR_MASK);
   assign w_wr_pend = csr_we && (csr_addr == CSR_PEND);
   assign w_wr_epc  = csr_we && (csr_addr == CSR_EPC);
   assign w_wr_vec  = csr_we && (csr_addr == CSR_VEC_BASE);

   // Register writes land before the redirect target is formed, so a
   // same-cycle EPC or VEC_BASE write is seen by RETURN / TAKE.
   assign w_epc_nxt = w_wr_epc ? csr_wdata : r_epc;
   assign w_vec_nxt = w_wr_vec ? {csr_wdata[XLEN-1:2], 2'b00} : r_vec_base;

`ifdef TRAP_VECTORED_EN
   assign w_vector = w_vec_nxt + (XLEN'(w_sel) << 2);
`else
   assign w_vector = w_vec_nxt;
`endif

   // OR-ing src_pulse in last makes a new event win over any clear.
   assign w_clr      = (w_wr_pend ? csr_wdata[NUM_SRC-1:0] : '0)
                     | (w_take ? (NUM_SRC'(1) << w_sel) : '0);
   assign w_pend_nxt = (r_pend & ~w_clr) | src_pulse;

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_ret       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_hit && boundary) begin
               w_take      = 1'b1;
               w_state_nxt = TAKE;
            end
         end
         TAKE:    w_state_nxt = HANDLER;
         HANDLER: begin
            if (mret) begin
               w_ret       = 1'b1;
               w_state_nxt = RETURN;
            end
         end
         RETURN:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_pend        <= '0;
         r_mask        <= '1;
         r_epc         <= '0;
         r_vec_base    <= RESET_VEC;
         r_cause       <= '0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pend     <= w_pend_nxt;
         r_vec_base <= w_vec_nxt;
         r_epc      <= w_take ? cur_pc : w_epc_nxt;
         if (w_wr_mask) r_mask <= csr_wdata[NUM_SRC-1:0];
         if (w_take) r_cause <= w_sel + CAUSE_W'(1);
         else if (r_state == RETURN) r_cause <= '0;
         r_redirect <= w_take | w_ret;
         if (w_take) r_redirect_pc <= w_vector;
         else if (w_ret) r_redirect_pc <= w_epc_nxt;
      end
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         CSR_MASK:     csr_rdata = XLEN'(r_mask);
         CSR_PEND:     csr_rdata = XLEN'(r_pend);
         CSR_EPC:      csr_rdata = r_epc;
         CSR_CAUSE:    csr_rdata = XLEN'(r_cause);
         CSR_VEC_BASE: csr_rdata = r_vec_base;
         default:      csr_rdata = '0;
      endcase
   end

   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;
   assign in_handler  = (r_state == HANDLER);

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the trap rules.
// Honours TRAP_VECTORED_EN for the expected vector address.
module tb_trap_ctrl;

`ifdef TRAP_VECTORED_EN
   localparam bit VECT = 1'b1;
`else
   localparam bit VECT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  src_pulse;
   logic        boundary;
   logic [31:0] cur_pc;
   logic        mret;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        in_handler;
   logic        csr_we;
   logic [2:0]  csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;

   always #5 clk = ~clk;

   trap_ctrl #(
      .XLEN      (32),
      .NUM_SRC   (8),
      .RESET_VEC (32'h0000_0300)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .src_pulse   (src_pulse),
      .boundary    (boundary),
      .cur_pc      (cur_pc),
      .mret        (mret),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .in_handler  (in_handler),
      .csr_we      (csr_we),
      .csr_addr    (csr_addr),
      .csr_wdata   (csr_wdata),
      .csr_rdata   (csr_rdata)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: mode 0 = running, 1 = entering handler, 2 = in handler, 3 = leaving.
   int          m_mode;
   logic [7:0]  m_pend;
   logic [7:0]  m_mask;
   logic [31:0] m_epc;
   logic [31:0] m_vec;
   logic [31:0] m_rpc;
   int          m_cause;
   bit          m_redir;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [2:0] a);
      case (a)
         3'd0:    return {24'b0, m_mask};
         3'd1:    return {24'b0, m_pend};
         3'd2:    return m_epc;
         3'd3:    return 32'(m_cause);
         3'd4:    return m_vec;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_edge(input logic rst, input logic [7:0] sp, input logic bnd,
                             input logic [31:0] pc, input logic mr, input logic we,
                             input logic [2:0] addr, input logic [31:0] wd);
      int          s;
      logic [7:0]  clr;
      logic [7:0]  mask_n;
      logic [31:0] epc_n;
      logic [31:0] vec_n;
      if (rst) begin
         m_mode = 0; m_pend = 8'h00; m_mask = 8'hFF; m_epc = 32'h0;
         m_vec = 32'h300; m_rpc = 32'h0; m_cause = 0; m_redir = 1'b0;
         return;
      end
      s      = lowest(m_pend & m_mask);
      clr    = 8'h00;
      mask_n = m_mask;
      epc_n  = m_epc;
      vec_n  = m_vec;
      if (we) begin
         case (addr)
            3'd0: mask_n = wd[7:0];
            3'd1: clr    = wd[7:0];
            3'd2: epc_n  = wd;
            3'd4: vec_n  = wd & ~32'h3;
            default: ;
         endcase
      end
      m_redir = 1'b0;
      case (m_mode)
         0: if (s >= 0 && bnd) begin
               m_mode  = 1;
               epc_n   = pc;
               m_cause = s + 1;
               clr[s]  = 1'b1;
               m_redir = 1'b1;
               m_rpc   = VECT ? vec_n + 32'(4 * s) : vec_n;
            end
         1: m_mode = 2;
         2: if (mr) begin
               m_mode  = 3;
               m_redir = 1'b1;
               m_rpc   = epc_n;
            end
         default: begin
            m_mode  = 0;
            m_cause = 0;
         end
      endcase
      m_pend = (m_pend & ~clr) | sp;
      m_mask = mask_n;
      m_epc  = epc_n;
      m_vec  = vec_n;
   endtask

   task automatic step(input logic rst, input logic [7:0] sp, input logic bnd,
                       input logic [31:0] pc, input logic mr, input logic we,
                       input logic [2:0] addr, input logic [31:0] wd);
      reset = rst; src_pulse = sp; boundary = bnd; cur_pc = pc; mret = mr;
      csr_we = we; csr_addr = addr; csr_wdata = wd;
      @(posedge clk);
      model_edge(rst, sp, bnd, pc, mr, we, addr, wd);
      #1;
      check("redirect", {31'b0, redirect}, {31'b0, m_redir});
      check("redirect_pc", redirect_pc, m_rpc);
      check("in_handler", {31'b0, in_handler}, {31'b0, (m_mode == 2)});
      check("csr_rdata", csr_rdata, exp_rd(addr));
   endtask

   task automatic nop();
      step(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0);
   endtask

   task automatic rd(input logic [2:0] a);
      step(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, a, 32'h0);
   endtask

   task automatic do_mret();
      step(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 32'h0);
   endtask

   initial begin
      // Reset and reset values
      step(1'b1, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0);
      step(1'b1, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0);
      check("rst_redirect", {31'b0, redirect}, 32'h0);
      rd(3'd0); check("rst_mask", csr_rdata, 32'hFF);
      rd(3'd1); check("rst_pend", csr_rdata, 32'h0);
      rd(3'd3); check("rst_cause", csr_rdata, 32'h0);
      rd(3'd4); check("rst_vec", csr_rdata, 32'h300);
      rd(3'd6); check("rst_addr6", csr_rdata, 32'h0);

      // Overflow trap: entry, registers, return
      step(1'b0, 8'h02, 1'b1, 32'h40, 1'b0, 1'b0, 3'd0, 32'h0);
      step(1'b0, 8'h00, 1'b1, 32'h40, 1'b0, 1'b0, 3'd0, 32'h0);
      check("t1_redirect", {31'b0, redirect}, 32'h1);
      check("t1_vector", redirect_pc, VECT ? 32'h304 : 32'h300);
      rd(3'd3); check("t1_cause", csr_rdata, 32'h2);
      rd(3'd2); check("t1_epc", csr_rdata, 32'h40);
      rd(3'd1); check("t1_pend", csr_rdata, 32'h0);
      do_mret(); check("t1_ret_pc", redirect_pc, 32'h40);
      rd(3'd3); check("t1_cause_clr", csr_rdata, 32'h0);

      // Two sources at once: lowest first, the other at the next boundary
      step(1'b0, 8'h05, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0);
      step(1'b0, 8'h00, 1'b1, 32'h80, 1'b0, 1'b0, 3'd0, 32'h0);
      check("t2_redirect", {31'b0, redirect}, 32'h1);
      rd(3'd3); check("t2_cause1", csr_rdata, 32'h1);
      rd(3'd1); check("t2_pend_left", csr_rdata, 32'h4);
      do_mret(); check("t2_ret_pc", redirect_pc, 32'h80);
      step(1'b0, 8'h00, 1'b1, 32'h84, 1'b0, 1'b0, 3'd0, 32'h0);
      check("t2_no_take_in_return", {31'b0, redirect}, 32'h0);
      step(1'b0, 8'h00, 1'b1, 32'h84, 1'b0, 1'b0, 3'd0, 32'h0);
      check("t2_second_take", {31'b0, redirect}, 32'h1);
      rd(3'd3); check("t2_cause3", csr_rdata, 32'h3);
      do_mret(); nop();

      // Masked source stays pending until unmasked
      step(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 3'd0, 32'hFE);
      step(1'b0, 8'h01, 1'b1, 32'h100, 1'b0, 1'b0, 3'd0, 32'h0);
      step(1'b0, 8'h00, 1'b1, 32'h100, 1'b0, 1'b0, 3'd1, 32'h0);
      check("t3_masked_no_redirect", {31'b0, redirect}, 32'h0);
      check("t3_pend", csr_rdata, 32'h1);
      step(1'b0, 8'h00, 1'b1, 32'h100, 1'b0, 1'b1, 3'd0, 32'hFF);
      step(1'b0, 8'h00, 1'b1, 32'h104, 1'b0, 1'b0, 3'd0, 32'h0);
      check("t3_take", {31'b0, redirect}, 32'h1);
      rd(3'd3); check("t3_cause1", csr_rdata, 32'h1);

      // No nesting: event in handler waits for return
      step(1'b0, 8'h08, 1'b1, 32'h200, 1'b0, 1'b0, 3'd0, 32'h0);
      step(1'b0, 8'h00, 1'b1, 32'h200, 1'b0, 1'b0, 3'd0, 32'h0);
      check("t4_no_nest", {31'b0, redirect}, 32'h0);
      do_mret(); check("t4_ret_pc", redirect_pc, 32'h104);
      step(1'b0, 8'h00, 1'b1, 32'h208, 1'b0, 1'b0, 3'd0, 32'h0);
      step(1'b0, 8'h00, 1'b1, 32'h208, 1'b0, 1'b0, 3'd0, 32'h0);
      check("t4_take", {31'b0, redirect}, 32'h1);
      rd(3'd3); check("t4_cause4", csr_rdata, 32'h4);
      do_mret(); nop();

      // Programmable vector base
      step(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 3'd4, 32'h1003);
      check("t5_vec_lowbits", csr_rdata, 32'h1000);
      step(1'b0, 8'h08, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0);
      step(1'b0, 8'h00, 1'b1, 32'h300, 1'b0, 1'b0, 3'd0, 32'h0);
      check("t5_vector", redirect_pc, VECT ? 32'h100C : 32'h1000);
      nop();
      // mret together with an EPC write returns to the new EPC
      step(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1, 3'd2, 32'h5550);
      check("t5_ret_new_epc", redirect_pc, 32'h5550);
      nop();

      // Reset during TAKE, then mret in IDLE
      step(1'b0, 8'h02, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0);
      step(1'b0, 8'h00, 1'b1, 32'h400, 1'b0, 1'b0, 3'd0, 32'h0);
      check("t6_take", {31'b0, redirect}, 32'h1);
      step(1'b1, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 3'd4, 32'h0);
      check("t6_rst_redirect", {31'b0, redirect}, 32'h0);
      check("t6_rst_in_handler", {31'b0, in_handler}, 32'h0);
      check("t6_rst_vec", csr_rdata, 32'h300);
      rd(3'd2); check("t6_rst_epc", csr_rdata, 32'h0);
      do_mret();
      check("t6_mret_idle", {31'b0, redirect}, 32'h0);
      check("t6_mret_idle_ih", {31'b0, in_handler}, 32'h0);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic        r_rst;
         logic [7:0]  r_sp;
         logic        r_we;
         logic [2:0]  r_addr;
         r_rst  = ($urandom_range(0, 79) == 0);
         r_sp   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         r_we   = ($urandom_range(0, 4) == 0);
         r_addr = 3'($urandom_range(0, 7));
         step(r_rst, r_sp, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
              ($urandom_range(0, 3) == 0), r_we, r_addr, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
